// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared encodings and constants for the iterative multiply/divide unit
package muldiv_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned ITERS = 32;
    localparam logic [4:0]  LAST_ITER = 5'(ITERS - 1);

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_FIN  = 2'b10
    } md_state_e;

    function automatic logic [XLEN-1:0] cond_neg32(input logic [XLEN-1:0] v, input logic neg);
        return neg ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// rtl/muldiv_step.sv - one radix-2 step per cycle: shift-add multiply or restoring divide on magnitudes
module muldiv_step
    import muldiv_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            load_i,
    input  logic            step_i,
    input  logic            is_div_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic [XLEN-1:0] acc_o,
    output logic [XLEN-1:0] q_o
);

    logic [XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0] q_q, q_d;
    logic [XLEN-1:0] b_q, b_d;
    logic [XLEN:0]   mul_sum;
    logic [XLEN:0]   div_shift;
    logic [XLEN-1:0] div_sub;
    logic            div_ge;

    // Multiply keeps {acc,q} as a right-shifting product/multiplier pair;
    // divide shifts the dividend out of q into the partial remainder acc.
    always_comb begin
        mul_sum   = {1'b0, acc_q} + (q_q[0] ? {1'b0, b_q} : 33'd0);
        div_shift = {acc_q, q_q[XLEN-1]};
        div_ge    = (div_shift >= {1'b0, b_q});
        div_sub   = div_shift[XLEN-1:0] - b_q;

        acc_d = acc_q;
        q_d   = q_q;
        b_d   = b_q;
        if (load_i) begin
            acc_d = '0;
            q_d   = a_i;
            b_d   = b_i;
        end else if (step_i) begin
            if (is_div_i) begin
                acc_d = div_ge ? div_sub : div_shift[XLEN-1:0];
                q_d   = {q_q[XLEN-2:0], div_ge};
            end else begin
                acc_d = mul_sum[XLEN:1];
                q_d   = {mul_sum[0], q_q[XLEN-1:1]};
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
            q_q   <= '0;
            b_q   <= '0;
        end else begin
            acc_q <= acc_d;
            q_q   <= q_d;
            b_q   <= b_d;
        end
    end

    assign acc_o = acc_q;
    assign q_o   = q_q;

endmodule

// File: rtl/muldiv_ctrl.sv
// rtl/muldiv_ctrl.sv - MULT/MULTU/DIV/DIVU sequencer with sign fix-up and the HI/LO registers
module muldiv_ctrl
    import muldiv_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            req_i,
    input  logic [1:0]      op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  logic            flush_i,
    input  logic [1:0]      mthl_i,
    output logic [XLEN-1:0] hi_o,
    output logic [XLEN-1:0] lo_o,
    output logic            busy_o,
    output logic            done_o,
    output logic            stall_o
);

    md_state_e       state_q, state_d;
    logic [4:0]      cnt_q, cnt_d;
    logic            is_div_q, is_div_d;
    logic            neg_res_q, neg_res_d;
    logic            neg_rem_q, neg_rem_d;
    logic            b_zero_q, b_zero_d;
    logic [XLEN-1:0] hi_q, hi_d;
    logic [XLEN-1:0] lo_q, lo_d;

    logic            op_signed;
    logic            a_neg;
    logic            b_neg;
    logic [XLEN-1:0] a_abs;
    logic [XLEN-1:0] b_abs;
    logic            load;
    logic            step;
    logic [XLEN-1:0] acc;
    logic [XLEN-1:0] quo;
    logic [63:0]     prod_fix;
    logic [XLEN-1:0] quot_fix;
    logic [XLEN-1:0] rem_fix;

    assign op_signed = (op_i == OP_MULT) || (op_i == OP_DIV);
    assign a_neg     = op_signed & a_i[XLEN-1];
    assign b_neg     = op_signed & b_i[XLEN-1];
    assign a_abs     = cond_neg32(a_i, a_neg);
    assign b_abs     = cond_neg32(b_i, b_neg);

    muldiv_step u_step (
        .clk      (clk),
        .rst      (rst),
        .load_i   (load),
        .step_i   (step),
        .is_div_i (is_div_q),
        .a_i      (a_abs),
        .b_i      (b_abs),
        .acc_o    (acc),
        .q_o      (quo)
    );

    // Divide-by-zero: the restoring loop already leaves |a| in the remainder,
    // so only the quotient needs forcing to all-ones.
    always_comb begin
        prod_fix = neg_res_q ? (~{acc, quo} + 64'd1) : {acc, quo};
        quot_fix = b_zero_q ? 32'hFFFF_FFFF : cond_neg32(quo, neg_res_q);
        rem_fix  = cond_neg32(acc, neg_rem_q);
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = '0;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        b_zero_d  = b_zero_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        load      = 1'b0;
        step      = 1'b0;
        done_o    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_i) begin
                    if (!flush_i) begin
                        load      = 1'b1;
                        is_div_d  = op_i[1];
                        neg_res_d = a_neg ^ b_neg;
                        neg_rem_d = a_neg;
                        b_zero_d  = (b_i == '0);
                        state_d   = ST_CALC;
                    end
                end else begin
                    if (mthl_i[1]) hi_d = a_i;
                    if (mthl_i[0]) lo_d = a_i;
                end
            end
            ST_CALC: begin
                if (flush_i) begin
                    state_d = ST_IDLE;
                end else begin
                    step  = 1'b1;
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == LAST_ITER) state_d = ST_FIN;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
                if (!flush_i) begin
                    done_o = 1'b1;
                    if (is_div_q) begin
                        hi_d = rem_fix;
                        lo_d = quot_fix;
                    end else begin
                        hi_d = prod_fix[63:32];
                        lo_d = prod_fix[31:0];
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            b_zero_q  <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            b_zero_q  <= b_zero_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign hi_o    = hi_q;
    assign lo_o    = lo_q;
    assign busy_o  = (state_q != ST_IDLE);
    assign stall_o = req_i & ~done_o & ~flush_i;

endmodule
